// File: rtl/mm_entry_driver_if.sv
// Bus bundle between the matching-memory write/probe driver and its surroundings:
// token input, joined-packet output, CAM entry broadcast/enables and status flags.
interface mm_entry_driver_if #(
  parameter int unsigned N_ENTRY = 8,
  parameter int unsigned DATA_W  = 16
);
  // token input
  logic                in_valid;
  logic                in_ready;
  logic [18:0]         in_cgdl;
  logic [DATA_W-1:0]   in_data;
  // CAM entry side
  logic [18:0]         cgdl_bc;
  logic [N_ENTRY-1:0]  entry_en;
  logic                entry_mr;
  logic [N_ENTRY-1:0]  entry_valid;
  logic [N_ENTRY-1:0]  entry_fire;
  // joined packet output
  logic                out_valid;
  logic                out_ready;
  logic [17:0]         out_key;
  logic [DATA_W-1:0]   out_data_l;
  logic [DATA_W-1:0]   out_data_r;
  // status
  logic                full;
  logic                ovf;
  logic                err;

  // driver view
  modport master (
    input  in_valid, in_cgdl, in_data, entry_valid, entry_fire, out_ready,
    output in_ready, cgdl_bc, entry_en, entry_mr, out_valid, out_key,
           out_data_l, out_data_r, full, ovf, err
  );

  // environment view (token source, CAM entries, packet sink)
  modport slave (
    output in_valid, in_cgdl, in_data, entry_valid, entry_fire, out_ready,
    input  in_ready, cgdl_bc, entry_en, entry_mr, out_valid, out_key,
           out_data_l, out_data_r, full, ovf, err
  );
endinterface

// File: rtl/mm_entry_driver.sv
// Matching-memory write/probe driver: captures an operand token, broadcasts its key to
// the CAM entries for one probe cycle, then either joins it with the fired partner,
// stores it into the lowest free entry, or drops it when the memory is full.
module mm_entry_driver #(
  parameter int unsigned N_ENTRY = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              cp,
  input  logic              mr_n,
  mm_entry_driver_if.master bus
);

  localparam int unsigned CGDL_W = 19;
  localparam int unsigned KEY_W  = 18;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [CGDL_W-1:0]   cap_q;
  logic [DATA_W-1:0]   capd_q;
  logic [CGDL_W-1:0]   last_q;
  logic [DATA_W-1:0]   ram_q [N_ENTRY];

  logic                out_valid_q;
  logic [KEY_W-1:0]    out_key_q;
  logic [DATA_W-1:0]   out_data_l_q;
  logic [DATA_W-1:0]   out_data_r_q;
  logic                ovf_q;
  logic                err_q;

  logic                accept;
  logic                do_pair;
  logic                do_store;
  logic                do_drop;
  logic                full_c;
  logic                fire_any;
  logic                fire_multi;
  logic [IDX_W-1:0]    fire_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                fire_found;
  logic                free_found;
  logic [DATA_W-1:0]   ram_rd;

  // Memory occupancy, fire detection and the duplicate-fire error condition.
  assign full_c     = &bus.entry_valid;
  assign fire_any   = |bus.entry_fire;
  assign fire_multi = (bus.entry_fire & (bus.entry_fire - N_ENTRY'(1))) != '0;
  assign ram_rd     = ram_q[fire_idx];

  // Lowest-index priority encoders for the fired entry and the first free entry.
  always_comb begin
    fire_idx   = '0;
    free_idx   = '0;
    fire_found = 1'b0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      if (bus.entry_fire[i] && !fire_found) begin
        fire_idx   = IDX_W'(i);
        fire_found = 1'b1;
      end
      if (!bus.entry_valid[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake and probe-cycle decisions.
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.entry_en = '0;
    accept       = 1'b0;
    do_pair      = 1'b0;
    do_store     = 1'b0;
    do_drop      = 1'b0;
    case (state_q)
      IDLE: begin
        // a token may enter only if the packet slot is empty or draining this edge
        bus.in_ready = !out_valid_q || bus.out_ready;
        if (bus.in_valid && bus.in_ready) begin
          accept  = 1'b1;
          state_d = PROBE;
        end
      end
      PROBE: begin
        state_d = IDLE;
        if (fire_any) begin
          do_pair = 1'b1;
        end else if (!full_c) begin
          do_store     = 1'b1;
          bus.entry_en = N_ENTRY'(1) << free_idx;
        end else begin
          do_drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured token and last-stored key; the captured key is only broadcast while probing.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      cap_q  <= '0;
      capd_q <= '0;
      last_q <= '0;
    end else begin
      if (accept) begin
        cap_q  <= bus.in_cgdl;
        capd_q <= bus.in_data;
      end
      if (do_store) begin
        last_q <= cap_q;
      end
    end
  end

  // Operand data storage, one word per CAM entry; contents are don't-care after reset.
  always_ff @(posedge cp) begin
    if (do_store) begin
      ram_q[free_idx] <= capd_q;
    end
  end

  // Joined packet register; the waiting operand's side is the opposite of the captured LR.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      out_valid_q  <= 1'b0;
      out_key_q    <= '0;
      out_data_l_q <= '0;
      out_data_r_q <= '0;
    end else if (do_pair) begin
      out_valid_q <= 1'b1;
      out_key_q   <= cap_q[CGDL_W-1:1];
      if (!cap_q[0]) begin
        out_data_l_q <= capd_q;
        out_data_r_q <= ram_rd;
      end else begin
        out_data_l_q <= ram_rd;
        out_data_r_q <= capd_q;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky overflow and duplicate-fire flags.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (do_drop) begin
        ovf_q <= 1'b1;
      end
      if (do_pair && fire_multi) begin
        err_q <= 1'b1;
      end
    end
  end

  // Output wiring.
  assign bus.cgdl_bc    = (state_q == PROBE) ? cap_q : last_q;
  assign bus.entry_mr   = !mr_n;
  assign bus.full       = full_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_key    = out_key_q;
  assign bus.out_data_l = out_data_l_q;
  assign bus.out_data_r = out_data_r_q;
  assign bus.ovf        = ovf_q;
  assign bus.err        = err_q;

endmodule
